// File: rtl/bitonic_pkg.sv
// rtl/bitonic_pkg.sv - shared types, CAS direction codes and index helper for the bitonic sequencer
package bitonic_pkg;

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  localparam logic CAS_DIR_ASC  = 1'b0;
  localparam logic CAS_DIR_DESC = 1'b1;

  // Spread p apart at bit position pos, leaving a 0 there (lower partner index of a pair).
  function automatic logic [31:0] insert_zero(input logic [31:0] p, input logic [4:0] pos);
    logic [31:0] low_mask;
    low_mask = (32'd1 << pos) - 32'd1;
    return ((p & ~low_mask) << 1) | (p & low_mask);
  endfunction

endpackage

// File: rtl/bitonic_seq_sorter_if.sv
// rtl/bitonic_seq_sorter_if.sv - input stream, output stream and CAS unit signals of the sequencer
interface bitonic_seq_sorter_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_desc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         cas_enable;
  logic         cas_dir;
  logic [W-1:0] cas_a;
  logic [W-1:0] cas_b;
  logic [W-1:0] cas_o1;
  logic [W-1:0] cas_o2;
  logic         busy;

  modport slave (
    input  in_valid, in_data, in_desc, out_ready, cas_o1, cas_o2,
    output in_ready, out_valid, out_data, out_last, cas_enable, cas_dir, cas_a, cas_b, busy
  );

  modport master (
    output in_valid, in_data, in_desc, out_ready, cas_o1, cas_o2,
    input  in_ready, out_valid, out_data, out_last, cas_enable, cas_dir, cas_a, cas_b, busy
  );
endinterface

// File: rtl/bitonic_pair_gen.sv
// rtl/bitonic_pair_gen.sv - steps (k, j, p) through the bitonic network and emits pair indices
module bitonic_pair_gen
  import bitonic_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 advance,
  output logic [$clog2(N)-1:0] i,
  output logic [$clog2(N)-1:0] l,
  output logic                 dir_raw,
  output logic                 substep_last,
  output logic                 sort_last
);
  localparam int IW = $clog2(N);

  // stage holds log2(k)-1 and j_lg holds log2(j), so every counter starts at 0.
  logic [IW-1:0] stage, j_lg, p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
      j_lg  <= '0;
      p     <= '0;
    end else if (start) begin
      stage <= '0;
      j_lg  <= '0;
      p     <= '0;
    end else if (advance) begin
      if (substep_last) begin
        p <= '0;
        if (j_lg == '0) begin
          stage <= stage + IW'(1);
          j_lg  <= stage + IW'(1);
        end else begin
          j_lg <= j_lg - IW'(1);
        end
      end else begin
        p <= p + IW'(1);
      end
    end
  end

  always_comb begin
    i            = IW'(insert_zero(32'(p), 5'(j_lg)));
    l            = i | (IW'(1) << j_lg);
    dir_raw      = (32'(i) & (32'd1 << (32'(stage) + 32'd1))) != 32'd0;
    substep_last = (p == IW'(N / 2 - 1));
    sort_last    = substep_last && (j_lg == '0) && (stage == IW'(IW - 1));
  end
endmodule

// File: rtl/bitonic_seq_sorter.sv
// rtl/bitonic_seq_sorter.sv - buffers a block, sorts it through one external CAS unit, streams it out
module bitonic_seq_sorter
  import bitonic_pkg::*;
#(
  parameter int N       = 8,
  parameter int W       = 32,
  parameter int CAS_LAT = 1
) (
  input logic                 clk,
  input logic                 rst,
  bitonic_seq_sorter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(CAS_LAT + 1);

  state_t             state, state_nx;
  logic [W-1:0]       mem [N];
  logic [IW-1:0]      wr_cnt, rd_cnt, pair_i, pair_l, iss_i, iss_l, wb_i, wb_l;
  logic [IW-1:0]      dl_i [CAS_LAT];
  logic [IW-1:0]      dl_l [CAS_LAT];
  logic [CAS_LAT-1:0] dl_valid;
  logic [CW-1:0]      gap_cnt;
  logic               desc_r, gap, done_r, dir_raw, substep_last, sort_last;
  logic               load_fire, load_last, drain_fire, drain_last, issue, gap_end, wb_valid;
  logic [W-1:0]       rd_a, rd_b, cas_a_r, cas_b_r;
  logic               cas_en_r, cas_dir_r, in_ready_c, out_valid_c, out_last_c, busy_c;

  bitonic_pair_gen #(.N(N)) u_pair_gen (
    .clk          (clk),
    .rst          (rst),
    .start        (load_last),
    .advance      (issue),
    .i            (pair_i),
    .l            (pair_l),
    .dir_raw      (dir_raw),
    .substep_last (substep_last),
    .sort_last    (sort_last)
  );

  assign load_fire  = (state == LOAD) && bus.in_valid;
  assign load_last  = load_fire && (wr_cnt == IW'(N - 1));
  assign drain_fire = (state == DRAIN) && bus.out_ready;
  assign drain_last = drain_fire && (rd_cnt == IW'(N - 1));
  assign issue      = (state == SORT) && !gap;
  // The final gap waits one extra cycle so the last writeback lands before DRAIN reads.
  assign gap_end    = (state == SORT) && gap && (gap_cnt == (done_r ? CW'(CAS_LAT) : CW'(CAS_LAT - 1)));
  assign wb_valid   = dl_valid[CAS_LAT-1];
  assign wb_i       = dl_i[CAS_LAT-1];
  assign wb_l       = dl_l[CAS_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    busy_c      = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready_c = 1'b1;
        if (load_last) state_nx = SORT;
      end
      SORT: begin
        busy_c = 1'b1;
        if (gap_end && done_r) state_nx = DRAIN;
      end
      DRAIN: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        out_last_c  = (rd_cnt == IW'(N - 1));
        if (drain_last) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // The first read of a substep coincides with the previous substep's last writeback; forward it.
  always_comb begin
    rd_a = mem[pair_i];
    rd_b = mem[pair_l];
    if (wb_valid && wb_i == pair_i)      rd_a = bus.cas_o1;
    else if (wb_valid && wb_l == pair_i) rd_a = bus.cas_o2;
    if (wb_valid && wb_i == pair_l)      rd_b = bus.cas_o1;
    else if (wb_valid && wb_l == pair_l) rd_b = bus.cas_o2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      desc_r    <= 1'b0;
      gap       <= 1'b0;
      gap_cnt   <= '0;
      done_r    <= 1'b0;
      cas_en_r  <= 1'b0;
      cas_dir_r <= CAS_DIR_ASC;
      cas_a_r   <= '0;
      cas_b_r   <= '0;
      iss_i     <= '0;
      iss_l     <= '0;
      dl_valid  <= '0;
      for (int s = 0; s < CAS_LAT; s++) begin
        dl_i[s] <= '0;
        dl_l[s] <= '0;
      end
    end else begin
      if (load_fire) begin
        wr_cnt <= load_last ? '0 : wr_cnt + IW'(1);
        if (wr_cnt == '0) desc_r <= bus.in_desc;
      end
      if (drain_fire) rd_cnt <= drain_last ? '0 : rd_cnt + IW'(1);

      cas_en_r  <= issue;
      cas_dir_r <= issue ? ((desc_r == CAS_DIR_DESC) ^ dir_raw) : CAS_DIR_ASC;
      cas_a_r   <= issue ? rd_a : '0;
      cas_b_r   <= issue ? rd_b : '0;
      iss_i     <= pair_i;
      iss_l     <= pair_l;

      if (load_last) begin
        gap     <= 1'b0;
        gap_cnt <= '0;
        done_r  <= 1'b0;
      end else if (issue && substep_last) begin
        gap     <= 1'b1;
        gap_cnt <= '0;
        done_r  <= sort_last;
      end else if (gap_end) begin
        gap    <= 1'b0;
        done_r <= 1'b0;
      end else if (state == SORT && gap) begin
        gap_cnt <= gap_cnt + CW'(1);
      end

      dl_valid[0] <= cas_en_r;
      dl_i[0]     <= iss_i;
      dl_l[0]     <= iss_l;
      for (int s = 1; s < CAS_LAT; s++) begin
        dl_valid[s] <= dl_valid[s-1];
        dl_i[s]     <= dl_i[s-1];
        dl_l[s]     <= dl_l[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) mem[wr_cnt] <= bus.in_data;
    if (wb_valid) begin
      mem[wb_i] <= bus.cas_o1;
      mem[wb_l] <= bus.cas_o2;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.out_last   = out_last_c;
  assign bus.out_data   = mem[rd_cnt];
  assign bus.busy       = busy_c;
  assign bus.cas_enable = cas_en_r;
  assign bus.cas_dir    = cas_dir_r;
  assign bus.cas_a      = cas_a_r;
  assign bus.cas_b      = cas_b_r;
endmodule
